// File: rtl/mcu_pkg.sv
// Shared MCU fetch definitions: default widths, reset PC and the fetch entry record.
package mcu_pkg;

    localparam int unsigned         MCU_XLEN     = 32;
    localparam int unsigned         MCU_ILEN     = 32;
    localparam logic [MCU_XLEN-1:0] MCU_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [MCU_XLEN-1:0] pc;
        logic [MCU_ILEN-1:0] instr;
        logic                err;
    } fetch_entry_t;

endpackage

// File: rtl/mcu_fetch_queue_if.sv
// Fetch-queue bus bundle: control, instruction-memory request/response and decode handoff.
interface mcu_fetch_queue_if
    import mcu_pkg::*;
#(
    parameter int unsigned XLEN = MCU_XLEN,
    parameter int unsigned ILEN = MCU_ILEN
);
    logic            fetch_en;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;

    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_gnt;
    logic            imem_rvalid;
    logic [ILEN-1:0] imem_rdata;
    logic            imem_err;

    logic            if_valid;
    logic [XLEN-1:0] if_pc;
    logic [ILEN-1:0] if_instr;
    logic            if_err;
    logic            if_ready;

    modport master (
        input  fetch_en, redirect_valid, redirect_pc,
        input  imem_gnt, imem_rvalid, imem_rdata, imem_err, if_ready,
        output imem_req, imem_addr, if_valid, if_pc, if_instr, if_err
    );

    modport slave (
        output fetch_en, redirect_valid, redirect_pc,
        output imem_gnt, imem_rvalid, imem_rdata, imem_err, if_ready,
        input  imem_req, imem_addr, if_valid, if_pc, if_instr, if_err
    );

endinterface

// File: rtl/mcu_sync_fifo.sv
// Synchronous FIFO with clear; push on full is accepted only together with a pop.
module mcu_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push_ok, pop_ok;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign dout  = mem_q[rptr_q];

    always_comb begin
        pop_ok  = pop && !empty;
        push_ok = push && (!full || pop_ok);
        mem_d   = mem_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (clear) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (push_ok) begin
                mem_d[wptr_q] = din;
                wptr_d        = wptr_q + AW'(1);
            end
            if (pop_ok) begin
                rptr_d = rptr_q + AW'(1);
            end
            if (push_ok && !pop_ok) begin
                count_d = count_q + CW'(1);
            end else if (!push_ok && pop_ok) begin
                count_d = count_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q   <= '{default: '0};
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/mcu_fetch_queue.sv
// Instruction prefetch: credit-limited in-order memory requests feeding a decode queue,
// with redirect flush that discards responses still in flight.
module mcu_fetch_queue
    import mcu_pkg::*;
#(
    parameter int unsigned     XLEN     = MCU_XLEN,
    parameter int unsigned     ILEN     = MCU_ILEN,
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(MCU_RESET_PC)
) (
    input logic               clk,
    input logic               rst_n,
    mcu_fetch_queue_if.master bus
);
    localparam int unsigned     CW   = $clog2(DEPTH) + 1;
    localparam int unsigned     SW   = CW + 1;
    localparam int unsigned     EW   = XLEN + ILEN + 1;
    localparam logic [XLEN-1:0] STEP = XLEN'(ILEN / 8);

    logic [XLEN-1:0] fpc_q, fpc_d, rpc_q, rpc_d;
    logic [CW-1:0]   out_q, out_d, disc_q, disc_d;
    logic            pend_q, pend_d;

    logic [CW-1:0]   fifo_count;
    logic            fifo_full, fifo_empty;
    logic [EW-1:0]   fifo_din, fifo_dout;
    logic [SW-1:0]   inflight;
    logic            credit, req, xfer, push, pop;

    always_comb begin
        inflight = {1'b0, out_q} + {1'b0, fifo_count};
        credit   = !fifo_full && (inflight < SW'(DEPTH));
        // A pending ungranted request stays up even if fetch_en drops, keeping addr stable.
        req      = rst_n && !bus.redirect_valid && (pend_q || (bus.fetch_en && credit));
        xfer     = req && bus.imem_gnt;
        push     = bus.imem_rvalid && (disc_q == '0) && !bus.redirect_valid;
        pop      = !fifo_empty && bus.if_ready;
        fifo_din = {rpc_q, bus.imem_rdata, bus.imem_err};
    end

    always_comb begin
        fpc_d  = fpc_q;
        rpc_d  = rpc_q;
        out_d  = out_q;
        disc_d = disc_q;
        pend_d = req && !bus.imem_gnt;
        if (xfer) begin
            fpc_d = fpc_q + STEP;
        end
        if (xfer && !bus.imem_rvalid) begin
            out_d = out_q + CW'(1);
        end else if (!xfer && bus.imem_rvalid) begin
            out_d = out_q - CW'(1);
        end
        if (bus.imem_rvalid && (disc_q != '0)) begin
            disc_d = disc_q - CW'(1);
        end
        if (push) begin
            rpc_d = rpc_q + STEP;
        end
        // Everything still outstanding after this cycle's accounting belongs to the old stream.
        if (bus.redirect_valid) begin
            fpc_d  = bus.redirect_pc;
            rpc_d  = bus.redirect_pc;
            disc_d = out_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fpc_q  <= RESET_PC;
            rpc_q  <= RESET_PC;
            out_q  <= '0;
            disc_q <= '0;
            pend_q <= 1'b0;
        end else begin
            fpc_q  <= fpc_d;
            rpc_q  <= rpc_d;
            out_q  <= out_d;
            disc_q <= disc_d;
            pend_q <= pend_d;
        end
    end

    mcu_sync_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_queue (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (bus.redirect_valid),
        .push  (push),
        .din   (fifo_din),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign bus.imem_req  = req;
    assign bus.imem_addr = fpc_q;
    assign bus.if_valid  = !fifo_empty;
    assign bus.if_pc     = fifo_empty ? '0   : fifo_dout[EW-1 -: XLEN];
    assign bus.if_instr  = fifo_empty ? '0   : fifo_dout[ILEN:1];
    assign bus.if_err    = fifo_empty ? 1'b0 : fifo_dout[0];

endmodule

// File: tb/tb_mcu_fetch_queue.sv
// Directed bench for mcu_fetch_queue; memory returns rdata = 0xA5A50000 ^ addr.
module tb_mcu_fetch_queue;
    import mcu_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mcu_fetch_queue_if #(.XLEN(32), .ILEN(32)) bus ();

    mcu_fetch_queue #(
        .XLEN     (32),
        .ILEN     (32),
        .DEPTH    (4),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int          ntests = 0;
    int          nfail  = 0;
    int unsigned cyc    = 0;
    int unsigned lat    = 1;
    int unsigned ngnt   = 0;
    logic [31:0] paddr[$];
    int unsigned pdue[$];
    logic        err_en   = 1'b0;
    logic [31:0] err_addr = '0;

    logic [31:0]  exp_a [5] = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10};
    logic [31:0]  exp_b [4] = '{32'h4, 32'h8, 32'hC, 32'h10};
    fetch_entry_t exp_e [4] = '{'{32'h0, 32'hA5A5_0000, 1'b0},
                                '{32'h4, 32'hA5A5_0004, 1'b1},
                                '{32'h8, 32'hA5A5_0008, 1'b0},
                                '{32'hC, 32'hA5A5_000C, 1'b0}};
    fetch_entry_t got;

    task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic respond();
        if (paddr.size() != 0 && pdue[0] <= cyc) begin
            bus.imem_rvalid = 1'b1;
            bus.imem_rdata  = 32'hA5A5_0000 ^ paddr[0];
            bus.imem_err    = err_en && (paddr[0] == err_addr);
        end else begin
            bus.imem_rvalid = 1'b0;
            bus.imem_rdata  = '0;
            bus.imem_err    = 1'b0;
        end
    endtask

    task automatic tick();
        logic        x;
        logic [31:0] a;
        logic        rv;
        #1;
        x  = bus.imem_req && bus.imem_gnt;
        a  = bus.imem_addr;
        rv = bus.imem_rvalid;
        @(posedge clk);
        #1;
        cyc++;
        if (rv && paddr.size() != 0) begin
            void'(paddr.pop_front());
            void'(pdue.pop_front());
        end
        if (x) begin
            paddr.push_back(a);
            pdue.push_back(cyc + lat - 1);
            ngnt++;
        end
        respond();
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        paddr.delete();
        pdue.delete();
        respond();
        #1;
        chk("rst_req",   {64'h0, bus.imem_req},  65'h0);
        chk("rst_valid", {64'h0, bus.if_valid},  65'h0);
        chk("rst_addr",  {33'h0, bus.imem_addr}, 65'h0);
        chk("rst_pc",    {33'h0, bus.if_pc},     65'h0);
        chk("rst_instr", {33'h0, bus.if_instr},  65'h0);
        chk("rst_err",   {64'h0, bus.if_err},    65'h0);
        @(posedge clk);
        #2;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        ngnt  = 0;
        #1;
        chk("post_rst_addr", {33'h0, bus.imem_addr}, 65'h0);
    endtask

    initial begin
        rst_n              = 1'b0;
        bus.fetch_en       = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.imem_gnt       = 1'b1;
        bus.imem_rvalid    = 1'b0;
        bus.imem_rdata     = '0;
        bus.imem_err       = 1'b0;
        bus.if_ready       = 1'b1;

        // Streaming fetch, one entry per cycle after fill
        lat = 1;
        do_reset();
        tick();
        chk("a_req1",   {64'h0, bus.imem_req},  65'h1);
        chk("a_addr1",  {33'h0, bus.imem_addr}, 65'h4);
        chk("a_valid1", {64'h0, bus.if_valid},  65'h0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("a_pc", {33'h0, bus.if_pc}, {33'h0, exp_a[i]});
        end
        chk("a_instr", {33'h0, bus.if_instr}, {33'h0, 32'hA5A5_0010});

        // Reset pulsed mid-burst, then stalled decode
        bus.if_ready = 1'b0;
        do_reset();
        chk("b_req0", {64'h0, bus.imem_req}, 65'h1);
        repeat (7) tick();
        chk("b_ngnt",  {33'h0, ngnt},          65'd4);
        chk("b_req",   {64'h0, bus.imem_req},  65'h0);
        chk("b_valid", {64'h0, bus.if_valid},  65'h1);
        chk("b_hold",  {33'h0, bus.if_pc},     65'h0);
        chk("b_addr",  {33'h0, bus.imem_addr}, 65'h10);
        bus.if_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("b_pc", {33'h0, bus.if_pc}, {33'h0, exp_b[i]});
            if (i == 0) begin
                chk("b_resume_req",  {64'h0, bus.imem_req},  65'h1);
                chk("b_resume_addr", {33'h0, bus.imem_addr}, 65'h10);
            end
        end

        // Redirect with two old responses in flight at latency 3
        lat = 3;
        do_reset();
        tick();
        tick();
        bus.fetch_en       = 1'b0;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h100;
        #1;
        chk("c_req_redir", {64'h0, bus.imem_req}, 65'h0);
        tick();
        bus.redirect_valid = 1'b0;
        bus.fetch_en       = 1'b1;
        #1;
        chk("c_valid", {64'h0, bus.if_valid},  65'h0);
        chk("c_req",   {64'h0, bus.imem_req},  65'h1);
        chk("c_addr",  {33'h0, bus.imem_addr}, 65'h100);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("c_drop", {64'h0, bus.if_valid}, 65'h0);
        end
        tick();
        chk("c_valid_new", {64'h0, bus.if_valid}, 65'h1);
        chk("c_pc",        {33'h0, bus.if_pc},    65'h100);
        chk("c_instr",     {33'h0, bus.if_instr}, {33'h0, 32'hA5A5_0100});

        // Grant withheld for five cycles at address 0x8
        lat = 1;
        do_reset();
        tick();
        tick();
        bus.imem_gnt = 1'b0;
        #1;
        chk("d_req",  {64'h0, bus.imem_req},  65'h1);
        chk("d_addr", {33'h0, bus.imem_addr}, 65'h8);
        chk("d_pc0",  {33'h0, bus.if_pc},     65'h0);
        for (int i = 0; i < 4; i++) begin
            tick();
            if (i == 0) begin
                bus.fetch_en = 1'b0;
                #1;
                chk("d_pc1", {33'h0, bus.if_pc}, 65'h4);
            end
            chk("d_req_hold",  {64'h0, bus.imem_req},  65'h1);
            chk("d_addr_hold", {33'h0, bus.imem_addr}, 65'h8);
        end
        bus.imem_gnt = 1'b1;
        bus.fetch_en = 1'b1;
        tick();
        chk("d_addr_next", {33'h0, bus.imem_addr}, 65'hC);
        tick();
        chk("d_pc8", {33'h0, bus.if_pc}, 65'h8);
        tick();
        chk("d_pcC", {33'h0, bus.if_pc}, 65'hC);

        // Bus error flagged on the entry for 0x4 only
        err_en   = 1'b1;
        err_addr = 32'h4;
        do_reset();
        tick();
        for (int i = 0; i < 4; i++) begin
            tick();
            got = '{pc: bus.if_pc, instr: bus.if_instr, err: bus.if_err};
            chk("e_entry", got, exp_e[i]);
        end
        err_en = 1'b0;

        // Back-to-back redirects, response coinciding with the first is dropped
        do_reset();
        tick();
        tick();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h200;
        #1;
        chk("f_req0", {64'h0, bus.imem_req}, 65'h0);
        tick();
        bus.redirect_pc = 32'h300;
        #1;
        chk("f_valid1", {64'h0, bus.if_valid}, 65'h0);
        chk("f_req1",   {64'h0, bus.imem_req}, 65'h0);
        tick();
        bus.redirect_valid = 1'b0;
        #1;
        chk("f_valid2", {64'h0, bus.if_valid},  65'h0);
        chk("f_req2",   {64'h0, bus.imem_req},  65'h1);
        chk("f_addr2",  {33'h0, bus.imem_addr}, 65'h300);
        tick();
        tick();
        chk("f_valid", {64'h0, bus.if_valid}, 65'h1);
        chk("f_pc",    {33'h0, bus.if_pc},    65'h300);
        chk("f_instr", {33'h0, bus.if_instr}, {33'h0, 32'hA5A5_0300});

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule

// File: doc/mcu_fetch_queue.md
MCU_FETCH_QUEUE -- requirements
Module: mcu_fetch_queue

Interface
REQ-001 SHALL have parameter XLEN, default 32, address/PC width.
REQ-002 SHALL have parameter ILEN, default 32, instruction width (multiple of 8).
REQ-003 SHALL have parameter DEPTH, default 4, instruction queue entries (power of 2, >=2).
REQ-004 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address.
REQ-005 SHALL have one clock and asynchronous active-low reset: clk  in  1  clock; rst_n  in  1  async reset, active low.
REQ-006 SHALL have ports: fetch_en  in  1  permit new requests.
REQ-007 redirect_valid  in  1  flush and restart fetch; redirect_pc  in  XLEN  new fetch address.
REQ-008 imem_req  out  1  request valid; imem_addr  out  XLEN  request address; imem_gnt  in  1  request accepted.
REQ-009 imem_rvalid  in  1  response valid (in order, any latency >=1); imem_rdata  in  ILEN  response data; imem_err  in  1  response bus error.
REQ-010 if_valid  out  1  entry available; if_pc  out  XLEN  entry PC; if_instr  out  ILEN  entry instruction; if_err  out  1  entry error; if_ready  in  1  decode accepts entry.

Function
REQ-011 Fetch PC fpc SHALL drive imem_addr; request transfer occurs on cycle with imem_req and imem_gnt both high.
REQ-012 imem_req SHALL assert when fetch_en high, redirect_valid low and outstanding+occupancy < DEPTH (credit rule).
REQ-013 Once asserted without grant, imem_req and imem_addr SHALL hold stable until grant, except on redirect.
REQ-014 On transfer, fpc SHALL advance by ILEN/8 next cycle (XLEN-bit wrap) and outstanding SHALL increment.
REQ-015 On imem_rvalid, outstanding SHALL decrement; if discard count is zero, {PC, rdata, err} SHALL be pushed to queue, else response dropped and discard count decremented.
REQ-016 Each pushed entry's PC SHALL equal the address of its request (response-PC tracked by in-order counter rpc).
REQ-017 Pushed entry SHALL appear on if_* the cycle after imem_rvalid (no bypass).
REQ-018 Pop SHALL occur when if_valid and if_ready; if_* SHALL hold stable while if_valid and not if_ready.
REQ-019 Simultaneous push and pop SHALL be legal at any occupancy including full; credit rule guarantees no overflow.
REQ-020 redirect_valid SHALL: clear queue, set fpc and rpc to redirect_pc, force imem_req low that cycle, set discard count = outstanding after that cycle's grant/response accounting.
REQ-021 Grant coinciding with redirect SHALL count as outstanding and be discarded; response coinciding with redirect SHALL be dropped.
REQ-022 if_valid SHALL be low the cycle after redirect; first new request SHALL issue the cycle after redirect.
REQ-023 Back-to-back redirects SHALL each restart; last redirect_pc wins.
REQ-024 fetch_en low SHALL stop new requests only; outstanding responses still complete and enqueue.
REQ-025 Counters SHALL be sized clog2(DEPTH)+1 bits; outstanding never exceeds DEPTH.

Reset
REQ-026 On rst_n low, asynchronously: fpc=rpc=RESET_PC, imem_req=0, if_valid=0, queue empty, outstanding=0, discard=0.
REQ-027 Reset mid-transaction SHALL abandon in-flight requests; memory responses before first post-reset request are the integrator's responsibility.
REQ-028 if_pc, if_instr, if_err SHALL be 0 while if_valid low after reset.

Structure
REQ-029 XLEN, ILEN, RESET_PC defaults and the fetch entry struct {pc, instr, err} SHALL live in shared package mcu_pkg.
REQ-030 Queue SHALL be sub-module mcu_sync_fifo (parametrised width/depth, push/pop/clear, full/empty/count).

Verification
REQ-031 Reset, fetch_en=1, gnt always 1, 1-cycle latency, if_ready=1 -> PCs 0x0,0x4,0x8... on if_pc, one per cycle after pipeline fill.
REQ-032 if_ready=0, DEPTH=4 -> exactly 4 grants then imem_req low; release if_ready -> entries 0x0..0xC in order, fetch resumes at 0x10.
REQ-033 Latency 3, 2 outstanding, redirect_pc=0x100 -> both old responses dropped, next if_pc=0x100.
REQ-034 Grant withheld 5 cycles -> imem_addr stable at 0x8 throughout; no PC skipped.
REQ-035 imem_err on response for 0x4 -> entry if_pc=0x4, if_err=1, following entries err=0.
REQ-036 rst_n pulsed low mid-burst -> all outputs at reset values immediately, next request at RESET_PC.
